// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle control FSM driving register, bus and ALU enables
// Outputs are decoded from state and IR; only IRin looks at Run.
module alu_sequencer (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic [15:0] DIN,
    output logic        IRin,
    output logic [7:0]  Rout,
    output logic [7:0]  Rin,
    output logic        DINout,
    output logic        Ain,
    output logic        Gin,
    output logic        Gout,
    output logic [2:0]  AluOp,
    output logic        Done
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;

    state_t      state_q, state_d;
    logic [8:0]  ir_q, ir_d;
    logic [2:0]  opcode;
    logic [7:0]  rx_oh, ry_oh;
    logic [2:0]  alu_field;
    logic        unused_din_hi;

    assign opcode        = ir_q[8:6];
    assign rx_oh         = 8'b1 << ir_q[5:3];
    assign ry_oh         = 8'b1 << ir_q[2:0];
    assign unused_din_hi = ^DIN[15:9];

    // ALU opcodes 010..111 map onto AluOp 000..101; mv/mvi leave it at 000
    always_comb begin
        alu_field = 3'b000;
        if (opcode != OP_MV && opcode != OP_MVI) begin
            alu_field = opcode - 3'd2;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        IRin    = 1'b0;
        Rout    = 8'h00;
        Rin     = 8'h00;
        DINout  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AluOp   = 3'b000;
        Done    = 1'b0;
        case (state_q)
            T0: begin
                IRin = Run;
                if (Run) begin
                    ir_d    = DIN[8:0];
                    state_d = T1;
                end
            end
            T1: begin
                AluOp = alu_field;
                if (opcode == OP_MV) begin
                    Rout    = ry_oh;
                    Rin     = rx_oh;
                    Done    = 1'b1;
                    state_d = T0;
                end else if (opcode == OP_MVI) begin
                    DINout  = 1'b1;
                    Rin     = rx_oh;
                    Done    = 1'b1;
                    state_d = T0;
                end else begin
                    Rout    = rx_oh;
                    Ain     = 1'b1;
                    state_d = T2;
                end
            end
            T2: begin
                AluOp   = alu_field;
                Rout    = ry_oh;
                Gin     = 1'b1;
                state_d = T3;
            end
            T3: begin
                AluOp   = alu_field;
                Gout    = 1'b1;
                Rin     = rx_oh;
                Done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= 9'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized and directed check of alu_sequencer against an ISA-level model
// Expected enables come from expanding each issued instruction into its cycle steps.
module tb_alu_sequencer;
    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Run;
    logic [15:0] DIN;
    logic        IRin, DINout, Ain, Gin, Gout, Done;
    logic [7:0]  Rout, Rin;
    logic [2:0]  AluOp;

    alu_sequencer dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
        .IRin(IRin), .Rout(Rout), .Rin(Rin), .DINout(DINout),
        .Ain(Ain), .Gin(Gin), .Gout(Gout), .AluOp(AluOp), .Done(Done)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [7:0] rout;
        logic [7:0] rin;
        logic       dinout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [2:0] aluop;
        logic       done;
    } step_t;

    step_t       exp_q[$];
    logic [8:0]  cur_ir;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] r    [8] = '{default: 16'h0};
    logic [15:0] arch [8] = '{default: 16'h0};
    logic [15:0] a_reg = 16'h0;
    logic [15:0] g_reg = 16'h0;
    logic [15:0] bus;

    function automatic logic [15:0] alu(input logic [2:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
            3'd4:    return x << y[3:0];
            3'd5:    return x >> y[3:0];
            default: return x;
        endcase
    endfunction

    // Bench-side datapath obeying whatever enables the sequencer drives
    always_comb begin
        bus = 16'h0;
        if (DINout) bus = DIN;
        else if (Gout) bus = g_reg;
        else for (int i = 0; i < 8; i++) if (Rout[i]) bus = r[i];
    end

    always @(posedge Clock) begin
        for (int i = 0; i < 8; i++) if (Rin[i]) r[i] <= bus;
        if (Ain) a_reg <= bus;
        if (Gin) g_reg <= alu(AluOp, a_reg, bus);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void expand(input logic [8:0] ir);
        step_t s;
        logic [2:0] op = ir[8:6];
        logic [7:0] rx = 8'b1 << ir[5:3];
        logic [7:0] ry = 8'b1 << ir[2:0];
        logic [2:0] ac = (op >= 3'd2) ? op - 3'd2 : 3'd0;
        if (op == 3'd0) begin
            s = '0; s.rout = ry; s.rin = rx; s.done = 1'b1; exp_q.push_back(s);
        end else if (op == 3'd1) begin
            s = '0; s.dinout = 1'b1; s.rin = rx; s.done = 1'b1; exp_q.push_back(s);
        end else begin
            s = '0; s.rout = rx; s.ain = 1'b1; s.aluop = ac; exp_q.push_back(s);
            s = '0; s.rout = ry; s.gin = 1'b1; s.aluop = ac; exp_q.push_back(s);
            s = '0; s.gout = 1'b1; s.rin = rx; s.aluop = ac; s.done = 1'b1; exp_q.push_back(s);
        end
    endfunction

    function automatic logic [24:0] outs();
        return {IRin, Rout, Rin, DINout, Ain, Gin, Gout, AluOp, Done};
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance, then check retirement
    task automatic cycle(input logic run, input logic [15:0] din);
        step_t s;
        logic  issued;
        logic [2:0] rx, ry, op;
        Run = run;
        DIN = din;
        #1;
        issued = 1'b0;
        if (exp_q.size() == 0) begin
            s = '0;
            check("outs_t0", outs(), {run, s});
            if (run) begin
                cur_ir = din[8:0];
                expand(din[8:0]);
                issued = 1'b1;
            end
        end else begin
            s = exp_q[0];
            check("outs", outs(), {1'b0, s});
        end
        check("bus_excl", 32'(($countones(Rout) + DINout + Gout) <= 1), 32'd1);
        @(posedge Clock);
        if (!issued && exp_q.size() != 0) void'(exp_q.pop_front());
        #1;
        if (!issued && s.done) begin
            op = cur_ir[8:6]; rx = cur_ir[5:3]; ry = cur_ir[2:0];
            if (op == 3'd0)      arch[rx] = arch[ry];
            else if (op == 3'd1) arch[rx] = din;
            else                 arch[rx] = alu(op - 3'd2, arch[rx], arch[ry]);
            check("reg_result", {16'h0, r[rx]}, {16'h0, arch[rx]});
        end
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b0;
        DIN    = 16'h0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_outs", outs(), 25'h0);
        Resetn = 1'b1;

        cycle(1'b1, 16'h0050);
        cycle(1'b0, 16'h0005);
        check("mvi_r2", {16'h0, r[2]}, 32'h5);

        cycle(1'b1, 16'h0012);
        cycle(1'b0, 16'h0000);
        cycle(1'b1, 16'h008A);
        cycle(1'b0, 16'h0000);
        cycle(1'b0, 16'h0000);
        cycle(1'b0, 16'h0000);

        foreach (exp_q[i]) exp_q.delete(i);
        for (int op = 3; op < 8; op++) begin
            cycle(1'b1, 16'(op << 6) | 16'h000A);
            repeat (3) cycle(1'(op & 1), 16'($urandom));
        end

        cycle(1'b1, 16'h0018);
        cycle(1'b1, 16'h0000);
        cycle(1'b1, 16'h009B);
        cycle(1'b1, 16'h01FF);
        cycle(1'b1, 16'h01FF);
        cycle(1'b1, 16'h01FF);
        cycle(1'b0, 16'h0000);

        cycle(1'b1, 16'h00CA);
        cycle(1'b0, 16'h01C0);
        cycle(1'b1, 16'h01FF);
        cycle(1'b0, 16'h0040);
        cycle(1'b0, 16'h0000);

        cycle(1'b1, 16'h008A);
        cycle(1'b0, 16'h0000);
        Resetn = 1'b0;
        #1;
        check("reset_async", outs(), 25'h0);
        exp_q.delete();
        #2;
        Resetn = 1'b1;
        repeat (5) cycle(1'b0, 16'($urandom));

        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom));
        end
        while (exp_q.size() != 0) cycle(1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control FSM that sequences the processor datapath around the shared bus, the A operand register, the `addsub` ALU and the G result register. It latches a 9-bit instruction from `DIN` when `Run` is asserted. It then drives one-hot register bus-drive/load enables, `Ain`, `Gin`, `Gout`, `DINout` and the 3-bit ALU control field until the instruction retires with a one-cycle `Done` pulse. It sits between the instruction source and the register file, bus mux and ALU, and owns all their enables.

## Interface
- No parameters; instruction width (9) and register count (8) are fixed.
- `Clock`  in  1  system clock, all state updates on rising edge
- `Resetn`  in  1  asynchronous, active-low reset
- `Run`  in  1  start request; sampled only in state T0
- `DIN`  in  16  instruction/immediate input; `DIN[8:0]` captured as IR in T0
- `IRin`  out  1  instruction-register load strobe, for observation
- `Rout`  out  8  one-hot register bus-drive enable (bit n drives Rn onto Bus)
- `Rin`  out  8  one-hot register load enable (bit n loads Rn from Bus)
- `DINout`  out  1  drive `DIN` onto Bus
- `Ain`  out  1  load A register from Bus
- `Gin`  out  1  load G register from ALU output
- `Gout`  out  1  drive G onto Bus
- `AluOp`  out  3  ALU control field for `addsub`
- `Done`  out  1  single-cycle retire pulse

## Operation
- IR fields: opcode `IR[8:6]`, RX `IR[5:3]` (destination, first operand), RY `IR[2:0]`.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 slt, 110 sll, 111 srl.
- ALU mapping on `AluOp`: add→000, sub→001, and→010, slt→011, sll→100, srl→101. For mv/mvi, `AluOp`=000.
- States: T0, T1, T2, T3; 2-bit encoded state register plus 9-bit IR.
- T0: `IRin`=1 iff `Run`=1. If `Run`=1, capture IR←`DIN[8:0]` and go to T1; otherwise stay in T0.
- T1, mv: `Rout[RY]`=1, `Rin[RX]`=1, `Done`=1; go to T0.
- T1, mvi: `DINout`=1, `Rin[RX]`=1, `Done`=1; go to T0. The immediate must be on `DIN` during T1.
- T1, ALU op: `Rout[RX]`=1, `Ain`=1; go to T2.
- T2: `Rout[RY]`=1, `Gin`=1, `AluOp` valid; go to T3.
- T3: `Gout`=1, `Rin[RX]`=1, `Done`=1; go to T0.
- mv with RX=RY asserts the same bit in `Rout` and `Rin`. This is legal: the register reloads its own value.
- Outputs are decoded combinationally from state and IR (Moore). `IRin` is the only output that depends on `Run`.
- `AluOp` is driven from IR in T1–T3 so it is stable before `Gin`. It is 000 in T0.
- Bus exclusivity invariant: at most one of {any `Rout` bit, `DINout`, `Gout`} is high in any cycle.
- `Run` is ignored in T1–T3. There is no queuing: a request must be re-presented or held in T0.

## Timing
- Reset (`Resetn`=0, asynchronous): state→T0, IR→0. Immediately `Rout`=`Rin`=0, `Ain`=`Gin`=`Gout`=`DINout`=`Done`=`IRin`=0 and `AluOp`=000, with `Run` low.
- Reset mid-instruction aborts it. No `Rin` or `Done` is asserted after reset assertion. Register contents already written are not rolled back.
- Latency from the `Run` sample edge to the `Done` cycle, inclusive: mv/mvi 2 cycles (T0, T1); ALU ops 4 cycles (T0–T3).
- `Run` held high gives back-to-back issue: the next T0 follows the `Done` cycle directly. Throughput is one instruction per 2 or 4 cycles.
- `Done` is high for exactly one cycle per instruction and never in T0 or T2.

## Test plan
- Reset: assert `Resetn`=0 mid-T2 of an add → all outputs 0 and state T0 with no clock edge. Release and hold `Run`=0 for 5 cycles → outputs stay 0.
- mvi R2,#0x0005: T0 `DIN`=9'b001_010_000; T1 `DIN`=0x0005 → T1 shows `DINout`=1, `Rin`=8'b0000_0100, `Done`=1.
- add R1,R2 (IR=010_001_010) → T1 `Rout`=0x02, `Ain`=1; T2 `Rout`=0x04, `Gin`=1, `AluOp`=000; T3 `Gout`=1, `Rin`=0x02, `Done`=1.
- Sweep sub/and/slt/sll/srl → `AluOp` in T2 is 001/010/011/100/101 respectively. Run full random with a datapath model and check the bus exclusivity invariant every cycle.
- Back-to-back: `Run` held high for mv R3,R0 then add R3,R3 → `Done` pulses at cycles 2 and 6, with `IRin` at cycles 1 and 3.
- `Run` toggled during T1–T3 of an ALU op → no IR change and no extra `IRin`; the instruction retires normally.
